mem_access_unit: RTL and testbench

//  MEM-stage consumer of the EX/MEM pipeline register. Turns memRead/memWrite into a req/ack transaction on a

---
 rtl/mem_access_unit_pkg.sv | 16 +
 rtl/mem_access_unit.sv | 116 +++++++++++
 tb/tb_mem_access_unit.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared sizes and state encoding for the MEM stage.
// Imported by the MEM-stage RTL.
package mem_access_unit_pkg;

  localparam int DSIZE_DEF   = 16;
  localparam int ASIZE_DEF   = 4;
  localparam int ISIZE_DEF   = 16;
  localparam int MADDR_DEF   = 8;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mem_access_unit.sv
// MEM stage: drives the req/ack data-memory bus, stalls upstream
// until completion and registers the MEM/WB writeback bundle.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DSIZE   = DSIZE_DEF,
  parameter int ASIZE   = ASIZE_DEF,
  parameter int ISIZE   = ISIZE_DEF,
  parameter int MADDR   = MADDR_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memRead_in,
  input  logic             memWrite_in,
  input  logic             memToReg_in,
  input  logic             jal_in,
  input  logic             WriteEn_in,
  input  logic [ASIZE-1:0] waddr_in,
  input  logic [ISIZE-1:0] npc_in,
  input  logic [DSIZE-1:0] alu_result_in,
  input  logic [DSIZE-1:0] rdata2_in,
  output logic             stall_out,
  output logic             dm_req,
  output logic             dm_we,
  output logic [MADDR-1:0] dm_addr,
  output logic [DSIZE-1:0] dm_wdata,
  input  logic             dm_ack,
  input  logic [DSIZE-1:0] dm_rdata,
  output logic [DSIZE-1:0] wdata_out,
  output logic [ASIZE-1:0] waddr_out,
  output logic             WriteEn_out,
  output logic             mem_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            mem_op;
  logic            expire;
  logic [DSIZE-1:0] exec_res;
  logic            unused_alu;

  assign mem_op     = memRead_in | memWrite_in;
  assign expire     = (cnt == LAST);
  assign exec_res   = jal_in ? DSIZE'(npc_in) : alu_result_in;
  assign unused_alu = ^alu_result_in[DSIZE-1:MADDR];

  // Held in reset, upstream must never see a stall.
  always_comb begin
    stall_out = 1'b0;
    if (!rst) begin
      unique case (state)
        ST_IDLE: stall_out = mem_op;
        ST_BUSY: stall_out = !dm_ack && !expire;
        default: stall_out = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      dm_req      <= 1'b0;
      dm_we       <= 1'b0;
      dm_addr     <= '0;
      dm_wdata    <= '0;
      wdata_out   <= '0;
      waddr_out   <= '0;
      WriteEn_out <= 1'b0;
      mem_err     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (mem_op) begin
            state       <= ST_BUSY;
            cnt         <= '0;
            dm_req      <= 1'b1;
            dm_we       <= memWrite_in;
            dm_addr     <= alu_result_in[MADDR-1:0];
            dm_wdata    <= rdata2_in;
            WriteEn_out <= 1'b0;
            if (memRead_in && memWrite_in)
              mem_err <= 1'b1;
          end else begin
            WriteEn_out <= WriteEn_in;
            waddr_out   <= waddr_in;
            wdata_out   <= exec_res;
          end
        end
        ST_BUSY: begin
          if (dm_ack) begin
            state       <= ST_IDLE;
            dm_req      <= 1'b0;
            WriteEn_out <= WriteEn_in && !dm_we;
            waddr_out   <= waddr_in;
            wdata_out   <= memToReg_in ? dm_rdata : exec_res;
          end else if (expire) begin
            state       <= ST_IDLE;
            dm_req      <= 1'b0;
            mem_err     <= 1'b1;
            WriteEn_out <= 1'b0;
          end else begin
            cnt         <= cnt + 1'b1;
            WriteEn_out <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; writebacks are
// checked by a scoreboard monitor decoupled from stimulus.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        memRead_in, memWrite_in, memToReg_in;
  logic        jal_in, WriteEn_in;
  logic [3:0]  waddr_in;
  logic [15:0] npc_in, alu_result_in, rdata2_in;
  logic        stall_out, dm_req, dm_we;
  logic [7:0]  dm_addr;
  logic [15:0] dm_wdata;
  logic        dm_ack;
  logic [15:0] dm_rdata, wdata_out;
  logic [3:0]  waddr_out;
  logic        WriteEn_out, mem_err;

  typedef struct {
    logic [3:0]  a;
    logic [15:0] d;
  } wb_t;

  wb_t exp_q[$];
  int  vectors = 0;
  int  errors  = 0;
  int  stalls;
  int  busy;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .memRead_in(memRead_in), .memWrite_in(memWrite_in),
    .memToReg_in(memToReg_in), .jal_in(jal_in),
    .WriteEn_in(WriteEn_in), .waddr_in(waddr_in),
    .npc_in(npc_in), .alu_result_in(alu_result_in),
    .rdata2_in(rdata2_in), .stall_out(stall_out),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack),
    .dm_rdata(dm_rdata), .wdata_out(wdata_out),
    .waddr_out(waddr_out), .WriteEn_out(WriteEn_out),
    .mem_err(mem_err)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    memRead_in    = 0;
    memWrite_in   = 0;
    memToReg_in   = 0;
    jal_in        = 0;
    WriteEn_in    = 0;
    waddr_in      = 0;
    npc_in        = 0;
    alu_result_in = 0;
    rdata2_in     = 0;
  endtask

  task automatic rand_in();
    memRead_in    = 1'($urandom);
    memWrite_in   = 1'($urandom);
    memToReg_in   = 1'($urandom);
    jal_in        = 1'($urandom);
    WriteEn_in    = 1'($urandom);
    waddr_in      = 4'($urandom);
    npc_in        = 16'($urandom);
    alu_result_in = 16'($urandom);
    rdata2_in     = 16'($urandom);
    dm_ack        = 1'($urandom);
    dm_rdata      = 16'($urandom);
  endtask

  task automatic push(input logic [3:0] a,
                      input logic [15:0] d);
    wb_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Every asserted WriteEn_out is one writeback to score.
  always @(negedge clk) begin
    if (WriteEn_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL wb_unexpected: got %h/%h expected none",
                 waddr_out, wdata_out);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        check("wb_waddr", 32'(waddr_out), 32'(e.a));
        check("wb_wdata", 32'(wdata_out), 32'(e.d));
      end
    end
  end

  initial begin
    rst = 1;
    rand_in();
    memRead_in = 1;
    repeat (2) step();
    @(negedge clk);
    check("rst_stall", 32'(stall_out), 0);
    check("rst_req", 32'(dm_req), 0);
    check("rst_we", 32'(dm_we), 0);
    check("rst_addr", 32'(dm_addr), 0);
    check("rst_wdata_dm", 32'(dm_wdata), 0);
    check("rst_wdata", 32'(wdata_out), 0);
    check("rst_waddr", 32'(waddr_out), 0);
    check("rst_wen", 32'(WriteEn_out), 0);
    check("rst_err", 32'(mem_err), 0);
    step();
    rst = 0;
    idle();
    dm_ack = 0;
    dm_rdata = 0;

    // ALU and jal pass-through, back to back
    WriteEn_in = 1; waddr_in = 3; alu_result_in = 16'h1234;
    push(3, 16'h1234);
    @(negedge clk);
    check("alu_stall", 32'(stall_out), 0);
    step();
    waddr_in = 5; alu_result_in = 16'hFFFF;
    push(5, 16'hFFFF);
    step();
    waddr_in = 7; jal_in = 1; npc_in = 16'h00AB;
    alu_result_in = 16'h1111;
    push(7, 16'h00AB);
    step();
    idle();
    step();

    // load, ack in fourth BUSY cycle
    memRead_in = 1; memToReg_in = 1; WriteEn_in = 1;
    waddr_in = 4; alu_result_in = 16'h0010;
    stalls = 0;
    @(negedge clk);
    if (stall_out) stalls++;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      check("ld_req", 32'(dm_req), 1);
      check("ld_addr", 32'(dm_addr), 32'h10);
      check("ld_we", 32'(dm_we), 0);
      if (stall_out) stalls++;
    end
    step();
    dm_ack = 1; dm_rdata = 16'hBEEF;
    push(4, 16'hBEEF);
    @(negedge clk);
    if (stall_out) stalls++;
    check("ld_stalls", 32'(stalls), 4);
    step();
    idle();
    dm_ack = 0;
    @(negedge clk);
    check("ld_req_drop", 32'(dm_req), 0);
    check("ld_wen", 32'(WriteEn_out), 1);

    // store, ack after one BUSY cycle
    step();
    memWrite_in = 1; WriteEn_in = 1; waddr_in = 6;
    rdata2_in = 16'hA5A5; alu_result_in = 16'h0020;
    @(negedge clk);
    check("st_stall0", 32'(stall_out), 1);
    step();
    @(negedge clk);
    check("st_req", 32'(dm_req), 1);
    check("st_we", 32'(dm_we), 1);
    check("st_wdata", 32'(dm_wdata), 32'hA5A5);
    check("st_addr", 32'(dm_addr), 32'h20);
    check("st_stall1", 32'(stall_out), 1);
    step();
    dm_ack = 1;
    @(negedge clk);
    check("st_wdata_hold", 32'(dm_wdata), 32'hA5A5);
    check("st_stall_ack", 32'(stall_out), 0);
    step();
    idle();
    dm_ack = 0;
    @(negedge clk);
    check("st_req_drop", 32'(dm_req), 0);
    check("st_no_wb", 32'(WriteEn_out), 0);

    // load that never completes
    check("to_err_pre", 32'(mem_err), 0);
    step();
    memRead_in = 1; WriteEn_in = 1; waddr_in = 9;
    alu_result_in = 16'h0033;
    step();
    busy = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (dm_req) busy++;
      check("to_stall", 32'(stall_out), (i == 14) ? 0 : 1);
      step();
      if (i == 14) idle();
    end
    check("to_busy_cycles", 32'(busy), 15);
    @(negedge clk);
    check("to_req_drop", 32'(dm_req), 0);
    check("to_err", 32'(mem_err), 1);
    check("to_no_wb", 32'(WriteEn_out), 0);
    check("to_stall_rel", 32'(stall_out), 0);
    repeat (3) step();
    @(negedge clk);
    check("to_err_sticky", 32'(mem_err), 1);

    // minimum-latency load, then jal, then reset mid-BUSY
    step();
    memRead_in = 1; memToReg_in = 1; WriteEn_in = 1;
    waddr_in = 2; alu_result_in = 16'h0050;
    step();
    dm_ack = 1; dm_rdata = 16'h1357;
    push(2, 16'h1357);
    @(negedge clk);
    check("ml_stall", 32'(stall_out), 0);
    step();
    idle();
    dm_ack = 0;
    WriteEn_in = 1; jal_in = 1; npc_in = 16'h0042;
    alu_result_in = 16'h9999; waddr_in = 15;
    push(15, 16'h0042);
    @(negedge clk);
    check("jal_stall", 32'(stall_out), 0);
    step();
    idle();
    memRead_in = 1; memToReg_in = 1; WriteEn_in = 1;
    waddr_in = 8; alu_result_in = 16'h0060;
    step();
    @(negedge clk);
    check("rb_req", 32'(dm_req), 1);
    step();
    rst = 1;
    step();
    @(negedge clk);
    check("rb_req_drop", 32'(dm_req), 0);
    check("rb_err_clr", 32'(mem_err), 0);
    check("rb_wen", 32'(WriteEn_out), 0);
    check("rb_stall", 32'(stall_out), 0);
    step();
    rst = 0;
    idle();
    dm_ack = 1; dm_rdata = 16'hDEAD;
    @(negedge clk);
    check("ia_stall", 32'(stall_out), 0);
    step();
    dm_ack = 0;
    @(negedge clk);
    check("ia_req", 32'(dm_req), 0);
    check("ia_wen", 32'(WriteEn_out), 0);

    // read+write conflict: write wins, error flagged
    step();
    memRead_in = 1; memWrite_in = 1; WriteEn_in = 1;
    waddr_in = 1; alu_result_in = 16'h0070;
    rdata2_in = 16'h0F0F;
    step();
    @(negedge clk);
    check("cf_we", 32'(dm_we), 1);
    check("cf_wdata", 32'(dm_wdata), 32'h0F0F);
    check("cf_err", 32'(mem_err), 1);
    step();
    dm_ack = 1;
    @(negedge clk);
    check("cf_stall", 32'(stall_out), 0);
    step();
    idle();
    dm_ack = 0;
    @(negedge clk);
    check("cf_req", 32'(dm_req), 0);
    check("cf_no_wb", 32'(WriteEn_out), 0);
    repeat (3) step();
    @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
